mcycle_unit: RTL and testbench

- Multi-cycle multiply/divide responder for the ARM-subset processor.
- Consumes the decoder's MS (start) and MCycleOp (0 = MUL, 1 = DIV) outputs together with the two register-file operands.
- Iterates one bit per cycle and returns two result words.
- Holds Busy so the datapath stalls until results are valid.

---
 rtl/mcycle_unit_pkg.sv | 13 +
 rtl/mcycle_div_step.sv | 28 ++
 rtl/mcycle_unit.sv | 125 ++++++++++++
 tb/tb_mcycle_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    MC_IDLE      = 2'b00,
    MC_COMPUTING = 2'b01,
    MC_DONE      = 2'b10
  } mc_state_e;

  localparam logic MC_OP_MUL = 1'b0;
  localparam logic MC_OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract divisor.
module mcycle_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Top bit of diff is the borrow of the trial subtraction.
  always_comb begin
    shifted = {rem_in, quot_in[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      rem_out  = shifted[WIDTH:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out  = diff[WIDTH:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply / divide unit, one bit per cycle.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mc_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             op_q, op_d;
  // Multiplicand (MUL) or divisor (DIV).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // Upper product half (MUL) or partial remainder (DIV).
  logic [WIDTH:0]   acc_q, acc_d;
  // Lower product half / multiplier (MUL) or quotient / dividend (DIV).
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quot;
  logic             last_iter;

  mcycle_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in  (acc_q),
    .quot_in (lo_q),
    .divisor (opnd_q),
    .rem_out (div_rem),
    .quot_out(div_quot)
  );

  // Next-state, datapath iteration and Busy/Done decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    result1_d = result1_q;
    result2_d = result2_q;
    Busy      = 1'b0;
    Done      = 1'b0;
    last_iter = (count_q == CW'(WIDTH - 1));
    mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);

    case (state_q)
      MC_IDLE: begin
        Busy = Start;
        if (Start) begin
          op_d    = MCycleOp;
          opnd_d  = (MCycleOp == MC_OP_MUL) ? Operand1 : Operand2;
          lo_d    = (MCycleOp == MC_OP_MUL) ? Operand2 : Operand1;
          acc_d   = '0;
          count_d = '0;
          state_d = MC_COMPUTING;
        end
      end
      MC_COMPUTING: begin
        Busy = 1'b1;
        if (op_q == MC_OP_DIV) begin
          acc_d = div_rem;
          lo_d  = div_quot;
        end else begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (last_iter) begin
          result1_d = lo_d;
          result2_d = acc_d[WIDTH-1:0];
          state_d   = MC_DONE;
        end
      end
      MC_DONE: begin
        Done    = 1'b1;
        state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= MC_IDLE;
      count_q   <= '0;
      op_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit (WIDTH = 32).
module tb_mcycle_unit;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic         MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .Start   (Start),
    .MCycleOp(MCycleOp),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .Result1 (Result1),
    .Result2 (Result2),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to the next cycle and drive inputs just after the edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full single-pulse operation, scrambling inputs while computing.
  task automatic run_vec(input int idx, input vec_t v);
    int busy_cnt;
    int early_done;
    busy_cnt   = 0;
    early_done = 0;
    next_cycle();
    Start    = 1'b1;
    MCycleOp = v.op;
    Operand1 = v.a;
    Operand2 = v.b;
    @(negedge CLK);
    if (Busy) busy_cnt++;
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      Start    = 1'b0;
      MCycleOp = 1'($urandom);
      Operand1 = $urandom;
      Operand2 = $urandom;
      @(negedge CLK);
      if (Busy) busy_cnt++;
      if (Done) early_done++;
    end
    chk($sformatf("v%0d busy_cycles", idx), 64'(busy_cnt), 64'd33);
    chk($sformatf("v%0d early_done", idx), 64'(early_done), 64'd0);
    next_cycle();
    @(negedge CLK);
    chk($sformatf("v%0d done_busy@33", idx), {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    chk($sformatf("v%0d result1", idx), 64'(Result1), 64'(v.r1));
    chk($sformatf("v%0d result2", idx), 64'(Result2), 64'(v.r2));
    next_cycle();
    @(negedge CLK);
    chk($sformatf("v%0d done_busy@34", idx), {62'd0, Done, Busy}, 64'd0);
    chk($sformatf("v%0d result1_hold", idx), 64'(Result1), 64'(v.r1));
  endtask

  initial begin
    int busy_cnt;

    vecs[0]  = '{1'b0, 32'd7,          32'd6,          32'd42,         32'd0};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE};
    vecs[2]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[3]  = '{1'b1, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
    vecs[5]  = '{1'b0, 32'h00010000,   32'h00010000,   32'h00000000,   32'h00000001};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[7]  = '{1'b0, 32'd0,          32'hFFFFFFFF,   32'd0,          32'd0};
    vecs[8]  = '{1'b0, 32'h12345678,   32'h00000100,   32'h34567800,   32'h00000012};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
    vecs[10] = '{1'b1, 32'd1000000,    32'd1000,       32'd1000,       32'd0};

    RESET    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset busy_done", {62'd0, Done, Busy}, 64'd0);
    chk("reset result1", 64'(Result1), 64'd0);
    chk("reset result2", 64'(Result2), 64'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Start held high: one op, ignored in DONE, re-accepted the cycle after.
    next_cycle();
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd7;
    Operand2 = 32'd6;
    busy_cnt = 0;
    @(negedge CLK);
    if (Busy) busy_cnt++;
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      @(negedge CLK);
      if (Busy) busy_cnt++;
    end
    chk("held busy_cycles", 64'(busy_cnt), 64'd33);
    next_cycle();
    MCycleOp = 1'b1;
    Operand1 = 32'd100;
    Operand2 = 32'd7;
    @(negedge CLK);
    chk("held done_busy@33", {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    chk("held result1", 64'(Result1), 64'd42);
    next_cycle();
    @(negedge CLK);
    chk("held busy@34", {62'd0, Done, Busy}, {62'd0, 1'b0, 1'b1});
    next_cycle();
    Start = 1'b0;
    busy_cnt = 0;
    @(negedge CLK);
    if (Busy) busy_cnt++;
    for (int c = 36; c <= 66; c++) begin
      next_cycle();
      @(negedge CLK);
      if (Busy) busy_cnt++;
    end
    chk("second busy_cycles", 64'(busy_cnt), 64'd32);
    next_cycle();
    @(negedge CLK);
    chk("second done_busy@67", {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    chk("second quotient", 64'(Result1), 64'd14);
    chk("second remainder", 64'(Result2), 64'd2);

    // Reset mid-divide aborts; following MUL is unaffected.
    next_cycle();
    next_cycle();
    Start    = 1'b1;
    MCycleOp = 1'b1;
    Operand1 = 32'd1000;
    Operand2 = 32'd3;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      Start    = 1'b0;
      Operand1 = $urandom;
      Operand2 = $urandom;
    end
    next_cycle();
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort busy_done@11", {62'd0, Done, Busy}, 64'd0);
    chk("abort result1", 64'(Result1), 64'd0);
    chk("abort result2", 64'(Result2), 64'd0);
    next_cycle();
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd3;
    Operand2 = 32'd4;
    @(negedge CLK);
    chk("restart busy@12", 64'(Busy), 64'd1);
    for (int c = 13; c <= 44; c++) begin
      next_cycle();
      Start    = 1'b0;
      MCycleOp = 1'($urandom);
      Operand1 = $urandom;
      Operand2 = $urandom;
    end
    next_cycle();
    @(negedge CLK);
    chk("restart done@45", {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    chk("restart result1", 64'(Result1), 64'd12);
    chk("restart result2", 64'(Result2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
